// File: rtl/kev_pkg.sv
// Shared types for the keycode event unit: event record, FSM states,
// HID keycodes of the game controls and their held_mask bit positions.
package kev_pkg;

    typedef struct packed {
        logic [7:0] code;
        logic       press;
        logic       is_repeat;
    } kev_evt_t;

    typedef enum logic [1:0] {
        IDLE,
        REL,
        PRS
    } kev_state_e;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_J     = 8'h0D;
    localparam logic [7:0] KC_K     = 8'h0E;
    localparam logic [7:0] KC_ESC   = 8'h29;

    localparam int HM_W     = 0;
    localparam int HM_S     = 1;
    localparam int HM_A     = 2;
    localparam int HM_D     = 3;
    localparam int HM_SPACE = 4;
    localparam int HM_J     = 5;
    localparam int HM_K     = 6;
    localparam int HM_ESC   = 7;

    function automatic logic [7:0] decode_held(input logic [7:0] kc);
        logic [7:0] m;
        m = '0;
        case (kc)
            KC_W:     m[HM_W]     = 1'b1;
            KC_S:     m[HM_S]     = 1'b1;
            KC_A:     m[HM_A]     = 1'b1;
            KC_D:     m[HM_D]     = 1'b1;
            KC_SPACE: m[HM_SPACE] = 1'b1;
            KC_J:     m[HM_J]     = 1'b1;
            KC_K:     m[HM_K]     = 1'b1;
            KC_ESC:   m[HM_ESC]   = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kev_fifo.sv
// Event FIFO; pointers carry one extra wrap bit so full and empty are
// distinguished without a counter.
module kev_fifo
    import kev_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  kev_evt_t wdata,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output kev_evt_t head
);

    localparam int AW = $clog2(DEPTH);

    kev_evt_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_pop;
    logic           do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/keycode_event_unit.sv
// Turns the SoC keycode export into press/release events plus a held-key mask.
// Define KEYCODE_AUTOREPEAT_EN to add frame_tick driven auto-repeat events.
module keycode_event_unit
    import kev_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_press,
    output logic       evt_repeat,
    output logic [7:0] held_mask,
    output logic       overflow,
    input  logic       ovf_clr
);

    kev_state_e state;
    logic [7:0] kc_q;
    logic [7:0] cur_key;
    logic [7:0] rel_key;
    logic       push;
    kev_evt_t   push_evt;
    logic       pop;
    logic       drop;
    logic       full;
    logic       empty;
    kev_evt_t   head;

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [CNT_W-1:0] rpt_cnt;
    logic             hold_steady;
    logic             rpt_fire;

    assign hold_steady = (state == IDLE) && (cur_key != KC_NONE) && (kc_q == cur_key);
    assign rpt_fire    = hold_steady && frame_tick && (rpt_cnt == FIRE_AT);
`endif

    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        case (state)
            REL: begin
                push     = 1'b1;
                push_evt = {rel_key, 1'b0, 1'b0};
            end
            PRS: begin
                push     = 1'b1;
                push_evt = {cur_key, 1'b1, 1'b0};
            end
            default: begin
`ifdef KEYCODE_AUTOREPEAT_EN
                if (rpt_fire) begin
                    push     = 1'b1;
                    push_evt = {cur_key, 1'b1, 1'b1};
                end
`endif
            end
        endcase
    end

    assign pop  = evt_valid && evt_ready;
    assign drop = push && full && !pop;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            kc_q      <= '0;
            cur_key   <= '0;
            rel_key   <= '0;
            held_mask <= '0;
            overflow  <= 1'b0;
`ifdef KEYCODE_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            kc_q      <= keycode;
            held_mask <= decode_held(kc_q);
            overflow  <= (overflow && !ovf_clr) || drop;
            case (state)
                IDLE: begin
                    if (kc_q != cur_key) begin
                        rel_key <= cur_key;
                        cur_key <= kc_q;
                        state   <= (cur_key != KC_NONE) ? REL : PRS;
                    end
                end
                REL:     state <= (cur_key != KC_NONE) ? PRS : IDLE;
                PRS:     state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef KEYCODE_AUTOREPEAT_EN
            // Counter only runs while a key is held unchanged; any change restarts it.
            if (hold_steady) begin
                if (frame_tick) rpt_cnt <= (rpt_cnt == FIRE_AT) ? RELOAD : rpt_cnt + CNT_W'(1);
            end else begin
                rpt_cnt <= '0;
            end
`endif
        end
    end

    kev_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign evt_valid = !empty;
    assign evt_code  = evt_valid ? head.code  : 8'h00;
    assign evt_press = evt_valid ? head.press : 1'b0;
`ifdef KEYCODE_AUTOREPEAT_EN
    assign evt_repeat = evt_valid ? head.is_repeat : 1'b0;
`else
    logic unused_bits;
    assign unused_bits = ^{frame_tick, head.is_repeat};
    assign evt_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_keycode_event_unit.sv
// Randomised and directed bench for keycode_event_unit against an event-list model.
`timescale 1ns/1ps
module tb_keycode_event_unit;

    localparam int DEPTH  = 4;
    localparam int RDELAY = 30;
    localparam int RRATE  = 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       frame_tick = 1'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_press;
    logic       evt_repeat;
    logic [7:0] held_mask;
    logic       overflow;

    keycode_event_unit #(
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_press  (evt_press),
        .evt_repeat (evt_repeat),
        .held_mask  (held_mask),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] code;
        logic       press;
        logic       rpt;
    } ev_t;

    ev_t        m_fifo [$];
    ev_t        m_pend [$];
    ev_t        seen [$];
    logic [7:0] m_kcq;
    logic [7:0] m_acc;
    logic [7:0] m_held;
    logic       m_ovf;
    int         m_ticks;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic ev_t mk(input logic [7:0] c, input logic p, input logic r);
        ev_t e;
        e.code  = c;
        e.press = p;
        e.rpt   = r;
        return e;
    endfunction

    function automatic logic [7:0] held_of(input logic [7:0] kc);
        case (kc)
            8'h1A:   return 8'h01;
            8'h16:   return 8'h02;
            8'h04:   return 8'h04;
            8'h07:   return 8'h08;
            8'h2C:   return 8'h10;
            8'h0D:   return 8'h20;
            8'h0E:   return 8'h40;
            8'h29:   return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    // Reference model: on each edge, pending work drains one event per edge;
    // otherwise a new sampled key schedules release/press events.
    always @(posedge Clk) begin : model
        ev_t  ev;
        logic have;
        logic popn;
        logic drop;
        int   sz;
        if (Reset) begin
            m_fifo.delete();
            m_pend.delete();
            m_kcq   = 8'h00;
            m_acc   = 8'h00;
            m_held  = 8'h00;
            m_ovf   = 1'b0;
            m_ticks = 0;
        end else begin
            have = 1'b0;
            ev   = '0;
            drop = 1'b0;
            popn = (m_fifo.size() > 0) && evt_ready;
            if (m_pend.size() > 0) begin
                ev   = m_pend.pop_front();
                have = 1'b1;
            end else if (m_kcq != m_acc) begin
                if (m_acc != 8'h00) m_pend.push_back(mk(m_acc, 1'b0, 1'b0));
                if (m_kcq != 8'h00) m_pend.push_back(mk(m_kcq, 1'b1, 1'b0));
                m_acc   = m_kcq;
                m_ticks = 0;
            end
`ifdef KEYCODE_AUTOREPEAT_EN
            else if (m_acc != 8'h00 && frame_tick) begin
                m_ticks++;
                if (m_ticks == RDELAY || (m_ticks > RDELAY && (m_ticks - RDELAY) % RRATE == 0)) begin
                    ev   = mk(m_acc, 1'b1, 1'b1);
                    have = 1'b1;
                end
            end
`endif
            sz = m_fifo.size();
            if (popn) void'(m_fifo.pop_front());
            if (have) begin
                if (sz < DEPTH || popn) m_fifo.push_back(ev);
                else drop = 1'b1;
            end
            m_ovf  = (m_ovf && !ovf_clr) || drop;
            m_held = held_of(m_kcq);
            m_kcq  = keycode;
        end
    end

    always @(negedge Clk) begin : compare
        if (Reset) begin
            chk("reset_outputs", {evt_valid, evt_code, evt_press, evt_repeat, held_mask, overflow}, 32'h0);
        end else begin
            chk("evt_valid", evt_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0)
                chk("evt_head", {evt_code, evt_press, evt_repeat}, m_fifo[0]);
            chk("held_mask", held_mask, m_held);
            chk("overflow", overflow, m_ovf);
            if (evt_valid && evt_ready) seen.push_back(mk(evt_code, evt_press, evt_repeat));
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int exp_n;
        int exp_rep;
        int nrep;
        int nbad;
        logic [7:0] keys [10];
        keys = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h0D, 8'h0E, 8'h29, 8'h55};

        cyc(3);
        #3;
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_overflow", overflow, 0);
        cyc(1);
        Reset = 1'b0;
        cyc(2);

        // 0 -> W: mask after two edges, event after three
        keycode = 8'h1A;
        cyc(2);
        #3;
        chk("w_held", held_mask, 8'h01);
        chk("w_not_yet", evt_valid, 0);
        cyc(1);
        #3;
        chk("w_valid", evt_valid, 1);
        chk("w_event", {evt_code, evt_press, evt_repeat}, mk(8'h1A, 1'b1, 1'b0));

        // W -> D with consumer ready: release then press on consecutive cycles
        cyc(1);
        evt_ready = 1'b1;
        cyc(1);
        keycode = 8'h07;
        cyc(2);
        #3;
        chk("d_held", held_mask, 8'h08);
        cyc(1);
        #3;
        chk("d_release", {evt_valid, evt_code, evt_press, evt_repeat}, {1'b1, mk(8'h1A, 1'b0, 1'b0)});
        cyc(1);
        #3;
        chk("d_press", {evt_valid, evt_code, evt_press, evt_repeat}, {1'b1, mk(8'h07, 1'b1, 1'b0)});
        cyc(1);
        #3;
        chk("d_drained", evt_valid, 0);

        // Reset while the A -> S release is pending
        cyc(1);
        keycode = 8'h04;
        cyc(6);
        keycode = 8'h16;
        cyc(2);
        Reset = 1'b1;
        #3;
        chk("rel_reset_empty", evt_valid, 0);
        cyc(2);
        Reset = 1'b0;
        evt_ready = 1'b0;
        cyc(6);
        #3;
        chk("post_reset_press", {evt_valid, evt_code, evt_press, evt_repeat}, {1'b1, mk(8'h16, 1'b1, 1'b0)});
        cyc(1);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        #3;
        chk("post_reset_single", evt_valid, 0);

        // Overflow: five toggles into a four-deep FIFO
        cyc(1);
        keycode = 8'h00;
        evt_ready = 1'b1;
        cyc(8);
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keycode = 8'h04;
            cyc(5);
            keycode = 8'h00;
            cyc(5);
        end
        #3;
        chk("ovf_set", overflow, 1);
        chk("ovf_head", {evt_valid, evt_code, evt_press, evt_repeat}, {1'b1, mk(8'h04, 1'b1, 1'b0)});
        cyc(1);
        seen.delete();
        evt_ready = 1'b1;
        cyc(8);
        evt_ready = 1'b0;
        #3;
        chk("ovf_retained", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("ovf_first", seen[0], mk(8'h04, 1'b1, 1'b0));
            chk("ovf_last", seen[3], mk(8'h04, 1'b0, 1'b0));
        end
        cyc(1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        #3;
        chk("ovf_cleared", overflow, 0);
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            keycode = 8'h04;
            cyc(5);
            keycode = 8'h00;
            cyc(5);
        end
        keycode = 8'h04;
        cyc(2);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        #3;
        chk("ovf_set_wins", overflow, 1);
        cyc(1);
        keycode = 8'h00;
        evt_ready = 1'b1;
        cyc(10);

        // Hold Space for 42 frame ticks
        seen.delete();
        keycode = 8'h2C;
        cyc(6);
        for (int i = 0; i < 42; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(2);
        end
        cyc(4);
`ifdef KEYCODE_AUTOREPEAT_EN
        exp_n = 4;
        exp_rep = 3;
`else
        exp_n = 1;
        exp_rep = 0;
`endif
        nrep = 0;
        nbad = 0;
        foreach (seen[i]) begin
            if (seen[i].rpt) nrep++;
            if (seen[i].code != 8'h2C || !seen[i].press) nbad++;
        end
        chk("rpt_events", seen.size(), exp_n);
        chk("rpt_repeats", nrep, exp_rep);
        chk("rpt_fields", nbad, 0);
        if (seen.size() > 0) chk("rpt_first_plain", seen[0].rpt, 0);
        keycode = 8'h00;
        cyc(6);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) keycode = keys[$urandom_range(0, 9)];
            evt_ready  = ($urandom_range(0, 9) < ((c % 400 < 100) ? 1 : 7));
            frame_tick = ($urandom_range(0, 2) == 0);
            ovf_clr    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) begin
                Reset = 1'b1;
                cyc(2);
                Reset = 1'b0;
            end
            cyc(1);
        end
        frame_tick = 1'b0;
        ovf_clr = 1'b0;
        cyc(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keycode_event_unit.md
KEYCODE_EVENT_UNIT -- requirements
Module: keycode_event_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two, range 2..16.
REQ-002 SHALL have parameter REPEAT_DELAY, default 30: frame_tick count from press to first repeat.
REQ-003 SHALL have parameter REPEAT_RATE, default 6: frame_tick count between subsequent repeats.
REQ-004 SHALL have ports:
  Clk  in  1  sole clock; same domain as the SoC keycode export.
  Reset  in  1  asynchronous, active-high.
  keycode  in  8  current USB HID keycode from the SoC keycode export; 0x00 means no key.
  frame_tick  in  1  one-cycle pulse per video frame.
  evt_valid  out  1  FIFO head holds an event.
  evt_ready  in  1  consumer accepts the head event.
  evt_code  out  8  head event keycode.
  evt_press  out  1  head event type: 1 = press or repeat, 0 = release.
  evt_repeat  out  1  head event is an auto-repeat.
  held_mask  out  8  game-control bits for the held key.
  overflow  out  1  sticky flag: an event was dropped.
  ovf_clr  in  1  clears overflow.

Function
REQ-005 SHALL register keycode into kc_q on every Clk edge.
REQ-006 SHALL implement FSM states IDLE, REL and PRS, holding an accepted key register cur_key.
REQ-007 SHALL, in IDLE with kc_q != cur_key: latch rel_key <= cur_key and cur_key <= kc_q, then go to REL if rel_key != 0, otherwise to PRS.
REQ-008 SHALL, in REL: push {rel_key, press=0, repeat=0}, then go to PRS if cur_key != 0, otherwise to IDLE.
REQ-009 SHALL, in PRS: push {cur_key, press=1, repeat=0}, then go to IDLE.
REQ-010 SHALL ignore keycode changes while in REL or PRS; the next IDLE comparison picks them up, and only the latest value is used.
REQ-011 Latency, FIFO empty: a 0->X change at edge k SHALL make evt_valid high after edge k+3. For an X->Y change, the release SHALL be at the head after edge k+3 and the press SHALL be queued after edge k+4.
REQ-012 FIFO SHALL pop on evt_valid && evt_ready; evt_* outputs SHALL show the head combinationally from FIFO storage.
REQ-013 Push with FIFO full and no pop in that cycle SHALL drop the event and set overflow. Push and pop in the same cycle while full SHALL succeed.
REQ-014 overflow SHALL clear on ovf_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-015 held_mask SHALL be registered from decode(kc_q), valid 2 cycles after a keycode change. Bit mapping: bit0 W 0x1A, bit1 S 0x16, bit2 A 0x04, bit3 D 0x07, bit4 Space 0x2C, bit5 J 0x0D, bit6 K 0x0E, bit7 Esc 0x29. Any other code SHALL give 0.

Reset
REQ-016 While Reset is high: FSM = IDLE; kc_q, cur_key, rel_key = 0; FIFO empty; evt_valid = 0; evt_code = 0; evt_press = 0; evt_repeat = 0; held_mask = 0; overflow = 0; repeat counter = 0.
REQ-017 Reset asserted mid-sequence (REL or PRS) SHALL abandon pending events. A key still held after release of Reset SHALL produce a fresh press event.

Configuration
REQ-018 With macro KEYCODE_AUTOREPEAT_EN defined:
  - In IDLE with cur_key != 0 and no key change, a frame counter SHALL count frame_tick.
  - On reaching REPEAT_DELAY, and every REPEAT_RATE ticks after that, the block SHALL push {cur_key, 1, 1}.
  - A key change SHALL reset the counter and take priority over a coincident repeat, which is suppressed.
  - Repeats SHALL follow the REQ-013 overflow rules.
REQ-019 Without KEYCODE_AUTOREPEAT_EN: no counter logic, frame_tick ignored, evt_repeat tied to 0.

Structure
REQ-020 Package kev_pkg SHALL hold:
  - the event struct {code[7:0], press, repeat};
  - the FSM state enum;
  - HID keycode constants;
  - held_mask bit-index constants.
REQ-021 The FIFO SHALL be a sub-module kev_fifo (parameterised depth, push, pop, full, empty, head). It SHALL use a wrapping pointer with an extra MSB for full/empty.

Verification
REQ-022 After Reset, keycode 0x00->0x1A at edge k -> evt_valid after edge k+3 with {0x1A,1,0}; held_mask = 0x01 after k+2.
REQ-023 keycode 0x1A->0x07, evt_ready = 1 -> events {0x1A,0,0} then {0x07,1,0} on consecutive cycles; held_mask = 0x08.
REQ-024 evt_ready = 0, five 0->key->0 toggles (FIFO_DEPTH 4) -> four events retained, overflow = 1. ovf_clr then clears it; ovf_clr coinciding with a drop leaves it at 1.
REQ-025 With KEYCODE_AUTOREPEAT_EN, hold 0x2C for 42 frame_ticks -> press, then repeats at ticks 30, 36 and 42, each {0x2C,1,1}. Without the macro -> press only.
REQ-026 Reset asserted in REL during 0x04->0x16 -> FIFO empty. After Reset release with keycode held at 0x16 -> single {0x16,1,0}.
